// File: rtl/sdram_pkg.sv
// Shared encodings and default widths for the SDRAM arbiter.
// The INIT_* states exist only when SDRAM_ARB_INIT_EN is defined.
package sdram_pkg;

  localparam int unsigned DEF_N_REQ  = 3;
  localparam int unsigned DEF_PADD_W = 23;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DQM_W  = 4;
  localparam int unsigned DEF_CMD_W  = 3;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_READA     = 3'd1,
    CMD_WRITEA    = 3'd2,
    CMD_REFRESH   = 3'd3,
    CMD_PRECHARGE = 3'd4,
    CMD_LOAD_MODE = 3'd5
  } sdram_cmd_e;

`ifdef SDRAM_ARB_INIT_EN
  typedef enum logic [3:0] {
    IDLE, CMD, LAT, DATA,
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE, CMD, LAT, DATA
  } arb_state_e;
`endif

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side and controller-side signals of the SDRAM arbiter.
// master = requesters plus controller model, slave = the arbiter.
interface sdram_arbiter_if #(
  parameter int unsigned N_REQ  = sdram_pkg::DEF_N_REQ,
  parameter int unsigned PADD_W = sdram_pkg::DEF_PADD_W,
  parameter int unsigned DATA_W = sdram_pkg::DEF_DATA_W,
  parameter int unsigned DQM_W  = sdram_pkg::DEF_DQM_W,
  parameter int unsigned CMD_W  = sdram_pkg::DEF_CMD_W
) ();

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        wr;
  logic [N_REQ*PADD_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ*DQM_W-1:0]  wdm;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        wready;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        done;
  logic                    init_done;
  logic [PADD_W-1:0]       paddr;
  logic [CMD_W-1:0]        cmd;
  logic [DQM_W-1:0]        dm;
  logic [DATA_W-1:0]       datain;
  logic                    cmdack;
  logic [DATA_W-1:0]       dataout;

  modport master (
    output req, wr, addr, wdata, wdm, cmdack, dataout,
    input  gnt, wready, rvalid, rdata, done, init_done, paddr, cmd, dm, datain
  );

  modport slave (
    input  req, wr, addr, wdata, wdm, cmdack, dataout,
    output gnt, wready, rvalid, rdata, done, init_done, paddr, cmd, dm, datain
  );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin front end sharing one SDRAM controller command port among N_REQ masters.
// Define SDRAM_ARB_INIT_EN to run the power-up init sequence before the first grant.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned PADD_W = DEF_PADD_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DQM_W  = DEF_DQM_W,
  parameter int unsigned CMD_W  = DEF_CMD_W,
  parameter int unsigned BURST  = 4,
  parameter int unsigned RD_LAT = 3
`ifdef SDRAM_ARB_INIT_EN
  ,
  parameter int unsigned       INIT_CYC  = 100,
  parameter logic [PADD_W-1:0] MODE_WORD = PADD_W'(32'h0000_0032)
`endif
) (
  input  logic            clk0,
  input  logic            reset,
  sdram_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned CNT_MAX = (BURST > RD_LAT) ? BURST : RD_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [PADD_W-1:0] paddr_q, paddr_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [N_REQ-1:0]  wready_q, wready_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              enter_data;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;

`ifdef SDRAM_ARB_INIT_EN
  localparam int unsigned INIT_W    = $clog2(INIT_CYC + 1);
  localparam arb_state_e  RST_STATE = INIT_WAIT;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
`else
  localparam arb_state_e  RST_STATE = IDLE;
`endif

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    ptr_d      = ptr_q;
    paddr_d    = paddr_q;
    cmd_d      = cmd_q;
    wready_d   = wready_q;
    rvalid_d   = rvalid_q;
    done_d     = done_q;
    enter_data = 1'b0;
`ifdef SDRAM_ARB_INIT_EN
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          wr_d    = bus.wr[pick_idx];
          paddr_d = bus.addr[pick_idx*PADD_W +: PADD_W];
          cmd_d   = bus.wr[pick_idx] ? CMD_W'(CMD_WRITEA) : CMD_W'(CMD_READA);
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.cmdack) begin
          cmd_d = CMD_W'(CMD_NOP);
          if (wr_q || RD_LAT <= 1) begin
            enter_data = 1'b1;
          end else begin
            state_d = LAT;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      LAT: begin
        if (cnt_q <= CNT_W'(1)) enter_data = 1'b1;
        else                    cnt_d = cnt_q - CNT_W'(1);
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          gnt_d    = '0;
          wready_d = '0;
          rvalid_d = '0;
          done_d   = '0;
          ptr_d    = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          done_d = (cnt_q == CNT_W'(1)) ? gnt_q : '0;
        end
      end
`ifdef SDRAM_ARB_INIT_EN
      INIT_WAIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYC - 1)) begin
          state_d = INIT_PRE;
          cmd_d   = CMD_W'(CMD_PRECHARGE);
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      INIT_PRE: begin
        if (bus.cmdack) begin
          state_d = INIT_REF1;
          cmd_d   = CMD_W'(CMD_REFRESH);
        end
      end
      INIT_REF1: begin
        if (bus.cmdack) state_d = INIT_REF2;
      end
      INIT_REF2: begin
        if (bus.cmdack) begin
          state_d = INIT_LMR;
          cmd_d   = CMD_W'(CMD_LOAD_MODE);
          paddr_d = MODE_WORD;
        end
      end
      INIT_LMR: begin
        if (bus.cmdack) begin
          state_d     = IDLE;
          cmd_d       = CMD_W'(CMD_NOP);
          paddr_d     = '0;
          init_done_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // First data beat: burst counter loaded, per-requester strobes raised
    if (enter_data) begin
      state_d  = DATA;
      cnt_d    = CNT_W'(BURST - 1);
      wready_d = wr_q ? gnt_q : '0;
      rvalid_d = wr_q ? '0 : gnt_q;
      done_d   = (BURST == 1) ? gnt_q : '0;
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      ptr_q    <= '0;
      paddr_q  <= '0;
      cmd_q    <= CMD_W'(CMD_NOP);
      wready_q <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
`ifdef SDRAM_ARB_INIT_EN
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      ptr_q    <= ptr_d;
      paddr_q  <= paddr_d;
      cmd_q    <= cmd_d;
      wready_q <= wready_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
`ifdef SDRAM_ARB_INIT_EN
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
`endif
    end
  end

`ifdef SDRAM_ARB_INIT_EN
  assign bus.init_done = init_done_q;
`else
  assign bus.init_done = 1'b1;
`endif

  assign bus.gnt    = gnt_q;
  assign bus.wready = wready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.done   = done_q;
  assign bus.paddr  = paddr_q;
  assign bus.cmd    = cmd_q;
  assign bus.rdata  = bus.dataout;
  // Write data and mask follow the granted requester without a register stage
  assign bus.datain = (|gnt_q) ? bus.wdata[idx_q*DATA_W +: DATA_W] : '0;
  assign bus.dm     = (|gnt_q) ? bus.wdm[idx_q*DQM_W +: DQM_W] : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter at default parameters.
// Define SDRAM_ARB_INIT_EN to also exercise the power-up init sequence.
module tb_sdram_arbiter;

  localparam int BURST  = 4;
  localparam int RD_LAT = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   oh_bad;

  sdram_arbiter_if bus ();

  sdram_arbiter dut (
    .clk0  (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wdata(input int r);
    case (r)
      0:       return 32'hA0A0_0000;
      1:       return 32'hB1B1_0001;
      default: return 32'hC2C2_0002;
    endcase
  endfunction

  function automatic logic [3:0] exp_wdm(input int r);
    case (r)
      0:       return 4'hA;
      1:       return 4'h5;
      default: return 4'hC;
    endcase
  endfunction

  task automatic wait_init();
    int n;
    n = 0;
    while (!bus.init_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("init_timeout", 64'(bus.init_done), 64'd1);
  endtask

  task automatic ack_step();
    bus.cmdack = 1'b1;
    @(negedge clk);
    bus.cmdack = 1'b0;
  endtask

  // One transaction from requester r, cmdack raised ack_dly cycles after cmd appears
  task automatic do_txn(input string tag, input int r, input bit w,
                        input logic [22:0] a, input int ack_dly);
    int n;
    int first;
    logic [2:0] oh;
    logic [31:0] dv;
    bit beat;
    oh = 3'(1 << r);
    bus.wr[r]          = w;
    bus.addr[r*23 +: 23] = a;
    bus.req[r]         = 1'b1;
    n = 0;
    while (bus.cmd == 3'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd1);
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(oh));
    check({tag, "_paddr"}, 64'(bus.paddr), 64'(a));
    check({tag, "_cmd"}, 64'(bus.cmd), w ? 64'd2 : 64'd1);
    check({tag, "_dm"}, 64'(bus.dm), 64'(exp_wdm(r)));
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      check({tag, "_cmd_hold"}, 64'(bus.cmd), w ? 64'd2 : 64'd1);
      check({tag, "_no_beat"}, 64'(bus.wready | bus.rvalid), 64'd0);
    end
    bus.cmdack = 1'b1;
    @(negedge clk);
    bus.cmdack = 1'b0;
    check({tag, "_cmd_nop"}, 64'(bus.cmd), 64'd0);
    first = w ? 1 : RD_LAT;
    for (int j = 1; j < first + BURST; j++) begin
      if (j > 1) @(negedge clk);
      beat = (j >= first);
      dv   = 32'hD000_0000 + 32'(j);
      bus.dataout = dv;
      #1;
      check({tag, "_wready"}, 64'(bus.wready), (w && beat) ? 64'(oh) : 64'd0);
      check({tag, "_rvalid"}, 64'(bus.rvalid), (!w && beat) ? 64'(oh) : 64'd0);
      check({tag, "_done"}, 64'(bus.done), (j == first + BURST - 1) ? 64'(oh) : 64'd0);
      if (w && beat) check({tag, "_datain"}, 64'(bus.datain), 64'(exp_wdata(r)));
      if (!w)        check({tag, "_rdata"}, 64'(bus.rdata), 64'(dv));
    end
    bus.req[r] = 1'b0;
    @(negedge clk);
    check({tag, "_idle_gnt"}, 64'(bus.gnt), 64'd0);
    check({tag, "_idle_datain"}, 64'(bus.datain), 64'd0);
  endtask

  // Serve whichever request the arbiter picks next and compare the grant
  task automatic serve(input string tag, input logic [2:0] exp_g);
    int n;
    n = 0;
    while (bus.cmd == 3'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gnt"}, 64'(bus.gnt), 64'(exp_g));
    ack_step();
    n = 0;
    while (bus.done == 3'd0 && n < 50) begin
      if (bus.gnt != 3'd0 && !$onehot(bus.gnt)) oh_bad++;
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(bus.done), 64'(exp_g));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int bad;
    clk         = 1'b0;
    reset       = 1'b1;
    checks      = 0;
    failures    = 0;
    oh_bad      = 0;
    bus.req     = '0;
    bus.wr      = '0;
    bus.addr    = '0;
    bus.wdata   = {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    bus.wdm     = {4'hC, 4'h5, 4'hA};
    bus.cmdack  = 1'b0;
    bus.dataout = '0;
`ifdef SDRAM_ARB_INIT_EN
    bus.req = 3'b100;
    bus.wr  = 3'b100;
`endif
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_beats", 64'({bus.wready, bus.rvalid, bus.done}), 64'd0);
    check("rst_cmd", 64'(bus.cmd), 64'd0);
    check("rst_paddr", 64'(bus.paddr), 64'd0);
    check("rst_dm_datain", 64'({bus.dm, bus.datain}), 64'd0);
`ifdef SDRAM_ARB_INIT_EN
    check("rst_init_done", 64'(bus.init_done), 64'd0);
`else
    check("rst_init_done", 64'(bus.init_done), 64'd1);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

`ifdef SDRAM_ARB_INIT_EN
    n   = 0;
    bad = 0;
    while (bus.cmd == 3'd0 && n < 400) begin
      if (bus.gnt != 3'd0 || bus.init_done) bad++;
      @(negedge clk);
      n++;
    end
    check("init_nop_cycles", 64'(n), 64'd100);
    check("init_cmd_pre", 64'(bus.cmd), 64'd4);
    ack_step();
    check("init_cmd_ref1", 64'(bus.cmd), 64'd3);
    ack_step();
    check("init_cmd_ref2", 64'(bus.cmd), 64'd3);
    ack_step();
    check("init_cmd_lmr", 64'(bus.cmd), 64'd5);
    check("init_mode_word", 64'(bus.paddr), 64'h32);
    if (bus.gnt != 3'd0 || bus.init_done) bad++;
    ack_step();
    check("init_done_rise", 64'(bus.init_done), 64'd1);
    check("init_cmd_nop", 64'(bus.cmd), 64'd0);
    check("init_no_early_gnt", 64'(bad), 64'd0);
    serve("init_req2", 3'b100);
    bus.req = '0;
    @(negedge clk);
`endif

    do_txn("wr1", 1, 1'b1, 23'h1234, 2);
    do_txn("rd0", 0, 1'b0, 23'h0ABC, 4);
    do_txn("wr2_slow_ack", 2, 1'b1, 23'h7F_FFFF, 20);

    bus.wr  = 3'b111;
    bus.req = 3'b111;
    serve("rr0", 3'b001);
    serve("rr1", 3'b010);
    serve("rr2", 3'b100);
    serve("rr3", 3'b001);
    bus.req = '0;
    check("rr_onehot", 64'(oh_bad), 64'd0);
    @(negedge clk);

    // Abort a burst from requester 2 in its second data beat
    bus.req = 3'b100;
    n = 0;
    while (bus.cmd == 3'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_gnt", 64'(bus.gnt), 64'b100);
    ack_step();
    check("abort_beat1", 64'(bus.wready), 64'b100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_gnt_clr", 64'(bus.gnt), 64'd0);
    check("abort_beats_clr", 64'({bus.wready, bus.rvalid, bus.done}), 64'd0);
    check("abort_cmd", 64'(bus.cmd), 64'd0);
    check("abort_bus_clr", 64'({bus.paddr, bus.dm, bus.datain}), 64'd0);
    reset   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    wait_init();
    bus.req = 3'b111;
    serve("post_rst", 3'b001);
    bus.req = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
